// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_e : grant FSM states
//   OWNER_*     : 1-bit owner tags stored in the outstanding-transaction FIFO
//   mem_cmd_t   : address-phase payload presented to the memory port
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              wr;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// Synchronous FIFO of 1-bit owner tags, one entry per accepted memory transaction.
//   clk, reset      : clock, synchronous active-high reset
//   push, push_tag  : enqueue a tag (ignored when full, fullness judged before pop)
//   pop             : dequeue the head (ignored when empty)
//   head_tag        : tag at the head
//   empty, full     : occupancy flags
module mem_port_arbiter_owner_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head_tag,
  output logic empty,
  output logic full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] tags_q, tags_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  // Pointers wrap modulo DEPTH so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign head_tag = tags_q[rd_ptr_q];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  // Next-state for storage, pointers and count.
  always_comb begin
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      tags_d[wr_ptr_q] = push_tag;
      wr_ptr_d         = ptr_next(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the fetch (inst) and data requesters.
// Grants the address phase, remembers owners of outstanding transactions in issue
// order and steers each in-order response back to its owner.
//   inst_*   : fetch requester (read only)
//   data_*   : data requester (read/write)
//   mem_*    : memory port (req/addr_ok address phase, data_ok response)
//   err_rsp  : sticky flag, response arrived with nothing outstanding
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_rsp
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state_q, state_d;
  logic                lock_owner_q, lock_owner_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                err_rsp_q, err_rsp_d;

  logic     grant_owner;
  logic     req_c;
  logic     push, pop;
  logic     fifo_head, fifo_empty, fifo_full;
  mem_cmd_t inst_cmd, data_cmd, grant_cmd;

  assign inst_cmd = '{wr: 1'b0, wstrb: '0, addr: inst_addr, wdata: '0};
  assign data_cmd = '{wr: data_wr, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};

  // Grant FSM: pick an owner in IDLE, freeze it in LOCK until the address is taken.
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    grant_owner  = OWNER_DATA;
    req_c        = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!fifo_full && (inst_req || data_req)) begin
          req_c = 1'b1;
          if (!data_req || (inst_req && (starve_q == STARVE_W'(STARVE_LIMIT)))) begin
            grant_owner = OWNER_INST;
          end
          if (!mem_addr_ok) begin
            state_d      = ARB_LOCK;
            lock_owner_d = grant_owner;
          end
        end
      end
      ARB_LOCK: begin
        req_c       = 1'b1;
        grant_owner = lock_owner_q;
        if (mem_addr_ok) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Address phase: fields follow the granted owner live, zeros when idle.
  assign mem_req   = req_c & ~reset;
  assign grant_cmd = !mem_req ? '0 : ((grant_owner == OWNER_INST) ? inst_cmd : data_cmd);
  assign mem_wr    = grant_cmd.wr;
  assign mem_wstrb = grant_cmd.wstrb;
  assign mem_addr  = grant_cmd.addr;
  assign mem_wdata = grant_cmd.wdata;

  assign push         = mem_req & mem_addr_ok;
  assign inst_addr_ok = push & (grant_owner == OWNER_INST);
  assign data_addr_ok = push & (grant_owner == OWNER_DATA);

  // Response steering: only the data_ok strobes are routed, rdata is shared.
  assign pop          = mem_data_ok & ~fifo_empty & ~reset;
  assign inst_data_ok = pop & (fifo_head == OWNER_INST);
  assign data_data_ok = pop & (fifo_head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err_rsp      = err_rsp_q;

  // Starvation counter and sticky orphan-response flag.
  always_comb begin
    starve_d  = starve_q;
    err_rsp_d = err_rsp_q;
    if (!inst_req || (push && grant_owner == OWNER_INST)) begin
      starve_d = '0;
    end else if (push && starve_q != STARVE_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
    if (mem_data_ok && fifo_empty) begin
      err_rsp_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      lock_owner_q <= OWNER_DATA;
      starve_q     <= '0;
      err_rsp_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      starve_q     <= starve_d;
      err_rsp_q    <= err_rsp_d;
    end
  end

  mem_port_arbiter_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_tag(grant_owner),
    .pop     (pop),
    .head_tag(fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an owner scoreboard.
module tb_mem_port_arbiter;

  localparam logic INST = 1'b0;
  localparam logic DATA = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err_rsp;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .err_rsp(err_rsp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Move to mid-cycle: inputs change 2 units after the edge, checks 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  // Expect the given owner on the port; on acceptance record it in the scoreboard.
  task automatic chk_grant(input string tag, input logic owner, input logic [31:0] addr);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_mem_addr"}, mem_addr, addr);
    chk({tag, "_inst_addr_ok"}, 32'(inst_addr_ok), 32'(mem_addr_ok && owner == INST));
    chk({tag, "_data_addr_ok"}, 32'(data_addr_ok), 32'(mem_addr_ok && owner == DATA));
    if (mem_addr_ok) exp_q.push_back(owner);
  endtask

  // Pop the oldest expected owner and compare response steering.
  task automatic chk_rsp(input string tag, input logic [31:0] rdata);
    logic owner;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=response expected=no_outstanding_entry", tag);
    end else begin
      owner = exp_q.pop_front();
      chk({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'(owner == INST));
      chk({tag, "_data_data_ok"}, 32'(data_data_ok), 32'(owner == DATA));
      chk({tag, "_inst_rdata"}, inst_rdata, rdata);
      chk({tag, "_data_rdata"}, data_rdata, rdata);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    // Reset: outputs quiet even with live requests and responses on the inputs.
    @(posedge clk); #2;
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    next_cycle();
    chk("rst_err_rsp", 32'(err_rsp), 32'd0);
    clear_inputs();
    reset = 1'b0;

    // 1: lone fetch, accepted at once, answered next cycle.
    next_cycle();
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
    #1;
    chk_grant("t1_grant", INST, 32'h1c00_0000);
    chk("t1_mem_wr", 32'(mem_wr), 32'd0);
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'h0280_0000;
    #1;
    chk_rsp("t1_rsp", 32'h0280_0000);

    // 2: simultaneous requests, data first then inst; responses steered in order.
    next_cycle();
    clear_inputs();
    inst_req = 1'b1; inst_addr = 32'h1c00_0004;
    data_req = 1'b1; data_addr = 32'h0000_0100; mem_addr_ok = 1'b1;
    #1;
    chk_grant("t2_first", DATA, 32'h0000_0100);
    next_cycle();
    data_req = 1'b0;
    #1;
    chk_grant("t2_second", INST, 32'h1c00_0004);
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'haaaa_0001;
    #1;
    chk_rsp("t2_rsp_a", 32'haaaa_0001);
    next_cycle();
    mem_rdata = 32'hbbbb_0002;
    #1;
    chk_rsp("t2_rsp_b", 32'hbbbb_0002);

    // 3: data held with inst pending: four data grants, then inst, then data again.
    //    Each cycle after the first also returns a response (push and pop together).
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      clear_inputs();
      inst_req = 1'b1; inst_addr = 32'h1c00_0040;
      data_req = 1'b1; data_addr = 32'h0000_0200 + 32'(i * 4); mem_addr_ok = 1'b1;
      mem_data_ok = (i > 0); mem_rdata = 32'h5000_0000 + 32'(i);
      #1;
      if (i > 0) chk_rsp($sformatf("t3_rsp%0d", i), 32'h5000_0000 + 32'(i));
      chk_grant($sformatf("t3_grant%0d", i), (i == 4) ? INST : DATA,
                (i == 4) ? 32'h1c00_0040 : 32'h0000_0200 + 32'(i * 4));
    end
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'h5000_0006;
    #1;
    chk_rsp("t3_rsp6", 32'h5000_0006);

    // 4: inst granted but stalled; a data request arriving later must not preempt.
    next_cycle();
    clear_inputs();
    inst_req = 1'b1; inst_addr = 32'h1c00_0080;
    #1;
    chk_grant("t4_stall0", INST, 32'h1c00_0080);
    next_cycle();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hf;
    data_addr = 32'h0000_0400; data_wdata = 32'hdead_beef;
    #1;
    chk_grant("t4_stall1", INST, 32'h1c00_0080);
    next_cycle();
    #1;
    chk_grant("t4_stall2", INST, 32'h1c00_0080);
    next_cycle();
    mem_addr_ok = 1'b1;
    #1;
    chk_grant("t4_accept", INST, 32'h1c00_0080);
    next_cycle();
    inst_req = 1'b0;
    #1;
    chk_grant("t4_write", DATA, 32'h0000_0400);
    chk("t4_mem_wr", 32'(mem_wr), 32'd1);
    chk("t4_mem_wstrb", 32'(mem_wstrb), 32'hf);
    chk("t4_mem_wdata", mem_wdata, 32'hdead_beef);

    // 5: two outstanding -> port closed; a pop in the full cycle does not reopen it.
    next_cycle();
    clear_inputs();
    data_req = 1'b1; data_addr = 32'h0000_0300; mem_addr_ok = 1'b1;
    #1;
    chk("t5_full_mem_req", 32'(mem_req), 32'd0);
    chk("t5_full_addr_ok", 32'(data_addr_ok), 32'd0);
    next_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_0011;
    #1;
    chk_rsp("t5_rsp_inst", 32'h0000_0011);
    chk("t5_full_pop_mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    mem_rdata = 32'h0000_0022;
    #1;
    chk_rsp("t5_rsp_wr", 32'h0000_0022);
    chk_grant("t5_push_pop", DATA, 32'h0000_0300);
    next_cycle();
    mem_data_ok = 1'b0; data_addr = 32'h0000_0304;
    #1;
    chk_grant("t5_refill", DATA, 32'h0000_0304);
    next_cycle();
    data_addr = 32'h0000_0308;
    #1;
    chk("t5_refull_mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    clear_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_0033;
    #1;
    chk_rsp("t5_drain0", 32'h0000_0033);
    next_cycle();
    mem_rdata = 32'h0000_0044;
    #1;
    chk_rsp("t5_drain1", 32'h0000_0044);

    // 6: orphan response -> no data_ok, sticky err_rsp until reset.
    next_cycle();
    chk("t6_err_before", 32'(err_rsp), 32'd0);
    mem_rdata = 32'h0000_0055;
    #1;
    chk("t6_orphan_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    next_cycle();
    clear_inputs();
    #1;
    chk("t6_err_set", 32'(err_rsp), 32'd1);
    next_cycle();
    #1;
    chk("t6_err_sticky", 32'(err_rsp), 32'd1);
    reset = 1'b1;
    next_cycle();
    #1;
    chk("t6_err_cleared", 32'(err_rsp), 32'd0);
    reset = 1'b0;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
